// File: rtl/hit_score_ctrl.sv
// Target-shooting score keeper: synchronizes N_TGT hit sensors, grants one hit
// per cycle round-robin, and runs a timed game that ends at MAX_SCORE or timeout.
module hit_score_ctrl #(
    parameter int N_TGT       = 4,
    parameter int LOCKOUT_CYC = 50_000_000,
    parameter int GAME_CYC    = 1_500_000_000,
    parameter int SCORE_W     = 3,
    parameter int MAX_SCORE   = 5,
    localparam int ID_W       = (N_TGT > 1) ? $clog2(N_TGT) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [N_TGT-1:0]   sensor,
    output logic [N_TGT-1:0]   armed,
    output logic [SCORE_W-1:0] score,
    output logic [MAX_SCORE:0] led,
    output logic               hit_valid,
    output logic [ID_W-1:0]    hit_id,
    output logic               game_over
);

    localparam int LOCK_W = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC) : 1;
    localparam int GAME_W = (GAME_CYC > 1) ? $clog2(GAME_CYC) : 1;
    localparam int LED_W  = MAX_SCORE + 1;

    localparam logic [LOCK_W-1:0]  LOCK_RELOAD = LOCK_W'(LOCKOUT_CYC - 1);
    localparam logic [GAME_W-1:0]  GAME_RELOAD = GAME_W'(GAME_CYC - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX   = SCORE_W'(MAX_SCORE);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [N_TGT-1:0]   sync1_q, sync1_d;
    logic [N_TGT-1:0]   sync2_q, sync2_d;
    logic [N_TGT-1:0]   sync3_q, sync3_d;
    logic [N_TGT-1:0]   armed_q, armed_d;
    logic [N_TGT-1:0]   pending_q, pending_d;
    logic [LOCK_W-1:0]  lock_q [N_TGT];
    logic [LOCK_W-1:0]  lock_d [N_TGT];
    logic [GAME_W-1:0]  timer_q, timer_d;
    logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]    hit_id_q, hit_id_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [LED_W-1:0]   led_q, led_d;
    logic               hit_valid_q, hit_valid_d;

    logic [N_TGT-1:0]   rise;
    logic [N_TGT-1:0]   accept;
    logic [SCORE_W-1:0] score_inc;
    logic               gnt_vld;
    logic [ID_W-1:0]    gnt_idx;
    logic               in_play;
    logic               restart;
    logic               enter_done;

    // Third sync stage only remembers the previous synchronized value for edge detect.
    assign rise      = sync2_q & ~sync3_q;
    assign accept    = rise & armed_q;
    assign score_inc = (score_q >= SCORE_MAX) ? score_q : score_q + 1'b1;

    // Round-robin: first pending target at or after rr_ptr_q, wrapping.
    always_comb begin : arbiter
        int unsigned      idx;
        logic [ID_W-1:0]  cand;
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        gnt_vld = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        cand    = '0;
        for (int k = 0; k < N_TGT; k++) begin
            idx  = (int'(rr_ptr_q) + k) % N_TGT;
            cand = ID_W'(idx);
            if (!gnt_vld && pending_q[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) state_d = PLAY;
            end
            PLAY: begin
                if ((gnt_vld && score_inc == SCORE_MAX) || timer_q == '0) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_play    = (state_q == PLAY);
        restart    = (state_q != PLAY) && start;
        enter_done = in_play && (state_d == DONE);
        game_over  = (state_q == DONE);
    end

    always_comb begin
        sync1_d     = sensor;
        sync2_d     = sync1_q;
        sync3_d     = sync2_q;
        armed_d     = armed_q;
        pending_d   = pending_q;
        lock_d      = lock_q;
        timer_d     = timer_q;
        score_d     = score_q;
        rr_ptr_d    = rr_ptr_q;
        hit_id_d    = hit_id_q;
        hit_valid_d = 1'b0;

        if (restart) begin
            score_d   = '0;
            armed_d   = '1;
            pending_d = '0;
            timer_d   = GAME_RELOAD;
            for (int i = 0; i < N_TGT; i++) lock_d[i] = '0;
        end else begin
            // Lockout keeps counting in every state; re-arming happens only in play.
            for (int i = 0; i < N_TGT; i++) begin
                if (lock_q[i] != '0) begin
                    lock_d[i] = lock_q[i] - 1'b1;
                    if (lock_q[i] == LOCK_W'(1) && in_play) armed_d[i] = 1'b1;
                end
            end

            if (in_play) begin
                if (timer_q != '0) timer_d = timer_q - 1'b1;

                pending_d = pending_d | accept;
                armed_d   = armed_d & ~accept;

                if (gnt_vld) begin
                    pending_d[gnt_idx] = 1'b0;
                    score_d            = score_inc;
                    hit_valid_d        = 1'b1;
                    hit_id_d           = gnt_idx;
                    lock_d[gnt_idx]    = LOCK_RELOAD;
                    if (LOCKOUT_CYC <= 1) armed_d[gnt_idx] = 1'b1;
                    rr_ptr_d = (int'(gnt_idx) == N_TGT - 1) ? '0 : gnt_idx + 1'b1;
                end

                // A grant on the final edge still counts; anything left pending is dropped.
                if (enter_done) begin
                    armed_d   = '0;
                    pending_d = '0;
                end
            end
        end

        led_d = LED_W'(1) << score_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            sync3_q     <= '0;
            armed_q     <= '0;
            pending_q   <= '0;
            timer_q     <= '0;
            rr_ptr_q    <= '0;
            hit_id_q    <= '0;
            score_q     <= '0;
            led_q       <= LED_W'(1);
            hit_valid_q <= 1'b0;
            // NOTE: the lockout array is a handful of counters, not a RAM, so it is reset like any flop.
            for (int i = 0; i < N_TGT; i++) lock_q[i] <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            armed_q     <= armed_d;
            pending_q   <= pending_d;
            timer_q     <= timer_d;
            rr_ptr_q    <= rr_ptr_d;
            hit_id_q    <= hit_id_d;
            score_q     <= score_d;
            led_q       <= led_d;
            hit_valid_q <= hit_valid_d;
            for (int i = 0; i < N_TGT; i++) lock_q[i] <= lock_d[i];
        end
    end

    assign armed     = armed_q;
    assign score     = score_q;
    assign led       = led_q;
    assign hit_valid = hit_valid_q;
    assign hit_id    = hit_id_q;

endmodule

// File: tb/tb_hit_score_ctrl.sv
// Bench for hit_score_ctrl: timestamp-based reference model compared every cycle,
// directed game scenarios with literal expectations, then randomized play.
module tb_hit_score_ctrl;

    localparam int N_TGT       = 4;
    localparam int LOCKOUT_CYC = 8;
    localparam int GAME_CYC    = 200;
    localparam int SCORE_W     = 3;
    localparam int MAX_SCORE   = 5;

    localparam int S_IDLE = 0;
    localparam int S_PLAY = 1;
    localparam int S_DONE = 2;

    logic               clk;
    logic               reset_n;
    logic               start;
    logic [N_TGT-1:0]   sensor;
    logic [N_TGT-1:0]   armed;
    logic [SCORE_W-1:0] score;
    logic [MAX_SCORE:0] led;
    logic               hit_valid;
    logic [1:0]         hit_id;
    logic               game_over;

    int n_vec  = 0;
    int n_miss = 0;

    hit_score_ctrl #(
        .N_TGT       (N_TGT),
        .LOCKOUT_CYC (LOCKOUT_CYC),
        .GAME_CYC    (GAME_CYC),
        .SCORE_W     (SCORE_W),
        .MAX_SCORE   (MAX_SCORE)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .sensor    (sensor),
        .armed     (armed),
        .score     (score),
        .led       (led),
        .hit_valid (hit_valid),
        .hit_id    (hit_id),
        .game_over (game_over)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: lockout and game end are absolute cycle stamps, sensors a sample history.
    int       m_state  = S_IDLE;
    int       m_score  = 0;
    int       m_rr     = 0;
    int       m_hid    = 0;
    bit       m_hv     = 1'b0;
    bit [3:0] m_armed  = '0;
    bit [3:0] m_pend   = '0;
    bit [3:0] h1 = '0, h2 = '0, h3 = '0;
    longint   m_rearm [4] = '{-1, -1, -1, -1};
    longint   m_deadline = -1;
    longint   m_cyc      = 0;

    task automatic model_reset();
        m_state = S_IDLE;
        m_score = 0;
        m_rr    = 0;
        m_hid   = 0;
        m_hv    = 1'b0;
        m_armed = '0;
        m_pend  = '0;
        h1 = '0;
        h2 = '0;
        h3 = '0;
        for (int i = 0; i < 4; i++) m_rearm[i] = -1;
        m_deadline = -1;
    endtask

    task automatic model_step();
        bit [3:0] rise_v;
        bit [3:0] armed_n;
        bit [3:0] pend_n;
        int       g;
        int       c;
        longint   e;
        e       = m_cyc;
        rise_v  = h2 & ~h3;
        armed_n = m_armed;
        pend_n  = m_pend;
        m_hv    = 1'b0;
        if (m_state != S_PLAY && start) begin
            m_state    = S_PLAY;
            m_score    = 0;
            armed_n    = 4'hF;
            pend_n     = 4'h0;
            m_deadline = e + GAME_CYC;
            for (int i = 0; i < 4; i++) m_rearm[i] = -1;
        end else if (m_state == S_PLAY) begin
            for (int i = 0; i < 4; i++)
                if (m_rearm[i] == e) armed_n[i] = 1'b1;
            for (int i = 0; i < 4; i++)
                if (rise_v[i] && m_armed[i]) begin
                    pend_n[i]  = 1'b1;
                    armed_n[i] = 1'b0;
                end
            g = -1;
            for (int k = 0; k < 4; k++) begin
                c = (m_rr + k) % 4;
                if (g < 0 && m_pend[c]) g = c;
            end
            if (g >= 0) begin
                pend_n[g] = 1'b0;
                if (m_score < MAX_SCORE) m_score++;
                m_hv       = 1'b1;
                m_hid      = g;
                m_rearm[g] = e + LOCKOUT_CYC - 1;
                m_rr       = (g + 1) % 4;
            end
            if ((g >= 0 && m_score == MAX_SCORE) || e == m_deadline) begin
                m_state = S_DONE;
                armed_n = 4'h0;
                pend_n  = 4'h0;
            end
        end
        m_armed = armed_n;
        m_pend  = pend_n;
        h3 = h2;
        h2 = h1;
        h1 = sensor;
        m_cyc++;
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    always @(negedge clk) begin
        check("armed",     32'(armed),     32'(m_armed));
        check("score",     32'(score),     32'(m_score));
        check("led",       32'(led),       32'(1) << m_score);
        check("hit_valid", 32'(hit_valid), 32'(m_hv));
        check("game_over", 32'(game_over), 32'(m_state == S_DONE));
        if (m_hv) check("hit_id", 32'(hit_id), 32'(m_hid));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic single_hit(input int t);
        sensor[t] = 1'b1;
        tick(2);
        sensor[t] = 1'b0;
        tick(4);
    endtask

    int rst_left;

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        sensor  = '0;
        tick(3);
        check("rst_score", 32'(score), 32'd0);
        check("rst_led", 32'(led), 32'h1);
        check("rst_armed", 32'(armed), 32'h0);
        check("rst_game_over", 32'(game_over), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // First hit on target 2: three-edge latency, then 8 cycles of lockout.
        start_pulse();
        sensor[2] = 1'b1;
        tick(3);
        check("t2_armed_low", 32'(armed[2]), 32'd0);
        check("t2_no_pulse_yet", 32'(hit_valid), 32'd0);
        tick(1);
        check("t2_hit_valid", 32'(hit_valid), 32'd1);
        check("t2_hit_id", 32'(hit_id), 32'd2);
        check("t2_score", 32'(score), 32'd1);
        check("t2_led", 32'(led), 32'h02);
        sensor[2] = 1'b0;
        tick(6);
        check("t2_lockout_end-1", 32'(armed[2]), 32'd0);
        tick(1);
        check("t2_rearmed", 32'(armed[2]), 32'd1);

        // Target 1 pulses twice inside its lockout: second edge dropped.
        sensor[1] = 1'b1;
        tick(2);
        sensor[1] = 1'b0;
        tick(2);
        sensor[1] = 1'b1;
        tick(2);
        sensor[1] = 1'b0;
        tick(8);
        check("t1_double_score", 32'(score), 32'd2);

        // Hit target 0 so the round-robin pointer lands on 1.
        single_hit(0);
        tick(8);
        check("t0_score", 32'(score), 32'd3);

        // Targets 0 and 3 together with rr_ptr=1: grant 3 then 0, reaching MAX_SCORE.
        sensor = 4'b1001;
        tick(4);
        check("rr_first_valid", 32'(hit_valid), 32'd1);
        check("rr_first_id", 32'(hit_id), 32'd3);
        check("rr_first_score", 32'(score), 32'd4);
        tick(1);
        check("rr_second_valid", 32'(hit_valid), 32'd1);
        check("rr_second_id", 32'(hit_id), 32'd0);
        check("max_score", 32'(score), 32'd5);
        check("max_game_over", 32'(game_over), 32'd1);
        check("max_armed", 32'(armed), 32'h0);
        sensor = '0;

        // Sixth edge after game over scores nothing.
        tick(2);
        sensor[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("done_no_hit", 32'(hit_valid), 32'd0);
        end
        check("done_score_held", 32'(score), 32'd5);
        sensor = '0;

        // Timeout game: no hits for GAME_CYC cycles.
        start_pulse();
        check("restart_armed", 32'(armed), 32'hF);
        check("restart_score", 32'(score), 32'd0);
        tick(GAME_CYC - 1);
        check("timer_not_yet", 32'(game_over), 32'd0);
        tick(1);
        check("timer_done", 32'(game_over), 32'd1);
        check("timer_score", 32'(score), 32'd0);
        start_pulse();
        check("replay_armed", 32'(armed), 32'hF);
        check("replay_game_over", 32'(game_over), 32'd0);

        // Reset mid-game with target 2 pending and score 3.
        single_hit(0);
        single_hit(1);
        single_hit(3);
        check("pre_reset_score", 32'(score), 32'd3);
        sensor[2] = 1'b1;
        tick(3);
        check("pre_reset_t2_taken", 32'(armed[2]), 32'd0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_score", 32'(score), 32'd0);
        check("mid_rst_led", 32'(led), 32'h1);
        check("mid_rst_armed", 32'(armed), 32'h0);
        check("mid_rst_hit_valid", 32'(hit_valid), 32'd0);
        check("mid_rst_hit_id", 32'(hit_id), 32'd0);
        check("mid_rst_game_over", 32'(game_over), 32'd0);
        tick(2);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("post_rst_no_hit", 32'(hit_valid), 32'd0);
        end
        sensor = '0;
        tick(2);

        // Randomized play with stray starts and occasional resets.
        rst_left = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < N_TGT; i++)
                if ($urandom_range(0, 5) == 0) sensor[i] = ~sensor[i];
            start = ($urandom_range(0, 39) == 0);
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) reset_n = 1'b1;
            end else if ($urandom_range(0, 599) == 0) begin
                reset_n  = 1'b0;
                rst_left = $urandom_range(1, 3);
            end
            tick(1);
        end
        reset_n = 1'b1;
        start   = 1'b0;
        tick(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
